// File: rtl/cim_pkg.sv
// Shared constants and types for the CIM activation feeder and its ping-pong buffers.
package cim_pkg;
    localparam int CIM_N_LANES = 32;
    localparam int CIM_ACT_W   = 4;
    localparam int CIM_OUT_W   = 13;

    typedef logic [4:0] lane_idx_t;
    typedef logic [CIM_N_LANES-1:0][CIM_ACT_W-1:0] act_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_CREDIT = 2'd1,
        ST_ISSUE       = 2'd2
    } issue_state_t;
endpackage

// File: rtl/cim_act_buffer.sv
// One half of the activation ping-pong: lane-indexed write port, full flag, parallel read.
module cim_act_buffer
    import cim_pkg::*;
#(
    parameter int N_LANES = CIM_N_LANES,
    parameter int ACT_W   = CIM_ACT_W,
    parameter int PTR_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [PTR_W-1:0]         wr_lane,
    input  logic [ACT_W-1:0]         wr_data,
    input  logic                     set_full,
    input  logic                     clr_full,
    output logic                     full,
    output logic [N_LANES*ACT_W-1:0] rd_data
);
    logic [N_LANES-1:0][ACT_W-1:0] mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (wr_en) begin
            mem[wr_lane] <= wr_data;
        end
    end

    // Set and clear never coincide on one half: a half being filled is never full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (set_full) begin
            full <= 1'b1;
        end else if (clr_full) begin
            full <= 1'b0;
        end
    end

    assign rd_data = mem;
endmodule

// File: rtl/cim_act_feeder.sv
// Serial-to-parallel activation feeder for the CIM adder tree, credit-gated issue.
// Optional macro CIM_FEEDER_PERF_EN adds perf_vec_cnt / perf_stall_cnt counters.
module cim_act_feeder
    import cim_pkg::*;
#(
    parameter int N_LANES         = CIM_N_LANES,
    parameter int ACT_W           = CIM_ACT_W,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [ACT_W-1:0]         in_data,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     input_valid,
    output logic [N_LANES*ACT_W-1:0] act_vec,
    input  logic                     tree_out_valid,
    output logic                     credit_err
`ifdef CIM_FEEDER_PERF_EN
    ,
    output logic [15:0]              perf_vec_cnt,
    output logic [15:0]              perf_stall_cnt
`endif
);
    localparam int PTR_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [PTR_W-1:0]                     wr_ptr;
    logic                                 wr_sel;
    logic                                 rd_sel;
    logic [1:0]                           full;
    logic [1:0][N_LANES*ACT_W-1:0]        rd_data;
    logic [CNT_W-1:0]                     outstanding;
    issue_state_t                         state;

    logic accept;
    logic last_beat;
    logic credit_ok;
    logic issue_fire;

    // in_ready depends only on registered state, never on in_valid.
    assign in_ready   = !full[wr_sel];
    assign accept     = in_valid && in_ready && !flush;
    assign last_beat  = (wr_ptr == PTR_W'(N_LANES - 1));
    assign credit_ok  = (outstanding < CNT_W'(MAX_OUTSTANDING));
    // The ISSUE state blocks a back-to-back pulse even when the other half is ready.
    assign issue_fire = (state != ST_ISSUE) && full[rd_sel] && credit_ok && !flush;

    for (genvar g = 0; g < 2; g++) begin : g_buf
        cim_act_buffer #(
            .N_LANES (N_LANES),
            .ACT_W   (ACT_W),
            .PTR_W   (PTR_W)
        ) u_buf (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .wr_en    (accept && (wr_sel == 1'(g))),
            .wr_lane  (wr_ptr),
            .wr_data  (in_data),
            .set_full (accept && last_beat && (wr_sel == 1'(g))),
            .clr_full (issue_fire && (rd_sel == 1'(g))),
            .full     (full[g]),
            .rd_data  (rd_data[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            wr_sel <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            wr_sel <= 1'b0;
        end else if (accept) begin
            if (last_beat) begin
                wr_ptr <= '0;
                wr_sel <= ~wr_sel;
            end else begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            input_valid <= 1'b0;
            act_vec     <= '0;
            rd_sel      <= 1'b0;
        end else begin
            input_valid <= issue_fire;
            if (issue_fire) begin
                act_vec <= rd_data[rd_sel];
                rd_sel  <= ~rd_sel;
            end else if (flush) begin
                rd_sel  <= 1'b0;
            end
            if (issue_fire) begin
                state <= ST_ISSUE;
            end else if (state == ST_ISSUE || flush || !full[rd_sel]) begin
                state <= ST_IDLE;
            end else begin
                state <= ST_WAIT_CREDIT;
            end
        end
    end

    // A return with nothing outstanding is a protocol error; the count holds at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            credit_err  <= 1'b0;
        end else begin
            unique case ({issue_fire, tree_out_valid})
                2'b10: outstanding <= outstanding + CNT_W'(1);
                2'b01: begin
                    if (outstanding == '0) begin
                        credit_err <= 1'b1;
                    end else begin
                        outstanding <= outstanding - CNT_W'(1);
                    end
                end
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef CIM_FEEDER_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_vec_cnt   <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (input_valid && perf_vec_cnt != 16'hFFFF) begin
                perf_vec_cnt <= perf_vec_cnt + 16'd1;
            end
            if (state == ST_WAIT_CREDIT && perf_stall_cnt != 16'hFFFF) begin
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_cim_act_feeder.sv
// Self-checking bench for cim_act_feeder: table-driven vectors plus corner sequences, scoreboarded issues.
module tb_cim_act_feeder;
    localparam int NL = 32;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic [AW-1:0]   in_data = '0;
    logic            in_ready;
    logic            flush = 1'b0;
    logic            input_valid;
    logic [NL*AW-1:0] act_vec;
    logic            tree_out_valid = 1'b0;
    logic            credit_err;
`ifdef CIM_FEEDER_PERF_EN
    logic [15:0]     perf_vec_cnt;
    logic [15:0]     perf_stall_cnt;
`endif

    cim_act_feeder #(
        .N_LANES         (NL),
        .ACT_W           (AW),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .flush          (flush),
        .input_valid    (input_valid),
        .act_vec        (act_vec),
        .tree_out_valid (tree_out_valid),
        .credit_err     (credit_err)
`ifdef CIM_FEEDER_PERF_EN
        ,
        .perf_vec_cnt   (perf_vec_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int issue_cnt = 0;
    int last_iss_cyc = 0;
    int last_acc_cyc = 0;
    logic [NL*AW-1:0] sb[$];

    typedef struct {
        logic [3:0] base;
        logic [3:0] step;
        logic [3:0] exp0;
        logic [3:0] exp15;
        logic [3:0] exp31;
    } vec_rec_t;
    vec_rec_t tbl[5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NL*AW-1:0] make_vec(input logic [3:0] base, input logic [3:0] step);
        logic [NL*AW-1:0] v;
        logic [3:0] x;
        x = base;
        v = '0;
        for (int i = 0; i < NL; i++) begin
            v[AW*i +: AW] = x;
            x = x + step;
        end
        return v;
    endfunction

    // Issue monitor: every input_valid pulse must match the oldest expected vector.
    initial begin
        logic prev_iv;
        prev_iv = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (input_valid) begin
                issue_cnt++;
                last_iss_cyc = cyc;
                check("iv_not_back_to_back", prev_iv, 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: got act_vec %0h expected no issue", act_vec);
                end else begin
                    check("act_vec", act_vec, sb.pop_front());
                end
            end
            prev_iv = input_valid;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [3:0] d);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) check("beat_stall_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic send_vec(input logic [3:0] base, input logic [3:0] step, input bit tov_last);
        logic [3:0] x;
        x = base;
        sb.push_back(make_vec(base, step));
        for (int i = 0; i < NL; i++) begin
            send_beat(x);
            x = x + step;
        end
        last_acc_cyc = cyc;
        in_valid = 1'b0;
        if (tov_last) begin
            tree_out_valid = 1'b1;
            @(negedge clk);
            tree_out_valid = 1'b0;
        end
    endtask

    task automatic wait_issue(input int target);
        int n;
        n = 0;
        while (issue_cnt < target && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("issue_count", issue_cnt, target);
    endtask

    task automatic pulse_tov();
        tree_out_valid = 1'b1;
        @(negedge clk);
        tree_out_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int base_cnt;
        tbl[0] = '{base: 4'h0, step: 4'h1, exp0: 4'h0, exp15: 4'hF, exp31: 4'hF};
        tbl[1] = '{base: 4'h5, step: 4'h0, exp0: 4'h5, exp15: 4'h5, exp31: 4'h5};
        tbl[2] = '{base: 4'hF, step: 4'h1, exp0: 4'hF, exp15: 4'hE, exp31: 4'hE};
        tbl[3] = '{base: 4'h3, step: 4'h2, exp0: 4'h3, exp15: 4'h1, exp31: 4'h1};
        tbl[4] = '{base: 4'hA, step: 4'hF, exp0: 4'hA, exp15: 4'hB, exp31: 4'hB};

        // Reset state
        idle(2);
        check("rst_in_ready", in_ready, 1);
        check("rst_input_valid", input_valid, 0);
        check("rst_act_vec", act_vec, 0);
        check("rst_credit_err", credit_err, 0);
`ifdef CIM_FEEDER_PERF_EN
        check("rst_perf_vec", perf_vec_cnt, 0);
        check("rst_perf_stall", perf_stall_cnt, 0);
`endif
        rst = 1'b0;
        idle(2);

        // Single vectors from the table, one credit returned after each
        for (int t = 0; t < 5; t++) begin
            base_cnt = issue_cnt;
            send_vec(tbl[t].base, tbl[t].step, 1'b0);
            check("in_ready_during_stream", in_ready, 1);
            wait_issue(base_cnt + 1);
            check("issue_latency", last_iss_cyc - last_acc_cyc, 1);
            check("lane0", act_vec[3:0], tbl[t].exp0);
            check("lane15", act_vec[63:60], tbl[t].exp15);
            check("lane31", act_vec[127:124], tbl[t].exp31);
            pulse_tov();
        end
        check("credit_err_clean", credit_err, 0);

        // Four vectors back-to-back with two credits: third and fourth wait for returns
        base_cnt = issue_cnt;
        send_vec(4'h1, 4'h1, 1'b0);
        send_vec(4'h2, 4'h3, 1'b0);
        send_vec(4'h7, 4'h0, 1'b0);
        send_vec(4'hC, 4'h5, 1'b0);
        idle(3);
        check("bp_issues_before_credit", issue_cnt, base_cnt + 2);
        check("bp_in_ready_low", in_ready, 0);
        idle(10);
        check("bp_still_stalled", issue_cnt, base_cnt + 2);
        pulse_tov();
        wait_issue(base_cnt + 3);
        idle(1);
        check("bp_in_ready_reopen", in_ready, 1);
        pulse_tov();
        wait_issue(base_cnt + 4);
        pulse_tov();
        pulse_tov();
        check("bp_credit_err", credit_err, 0);

        // Credit return coinciding with an issue leaves the count unchanged
        base_cnt = issue_cnt;
        send_vec(4'h4, 4'h1, 1'b0);
        wait_issue(base_cnt + 1);
        send_vec(4'h8, 4'h2, 1'b1);
        wait_issue(base_cnt + 2);
        check("same_cycle_credit_err", credit_err, 0);
        send_vec(4'h9, 4'h1, 1'b0);
        wait_issue(base_cnt + 3);
        send_vec(4'hD, 4'h0, 1'b0);
        idle(15);
        check("same_cycle_limit_holds", issue_cnt, base_cnt + 3);
        pulse_tov();
        wait_issue(base_cnt + 4);
        pulse_tov();
        pulse_tov();

        // Flush drops a partial vector and the beat offered alongside it
        base_cnt = issue_cnt;
        for (int i = 0; i < 17; i++) send_beat(4'h5);
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = 4'h7;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_in_ready", in_ready, 1);
        idle(3);
        check("flush_no_issue", issue_cnt, base_cnt);
        send_vec(4'hA, 4'h0, 1'b0);
        wait_issue(base_cnt + 1);
        pulse_tov();

        // Credit return with nothing outstanding is flagged and sticky
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("cerr_after_rst", credit_err, 0);
        pulse_tov();
        check("cerr_set", credit_err, 1);
        idle(5);
        check("cerr_sticky", credit_err, 1);
        base_cnt = issue_cnt;
        send_vec(4'h9, 4'h1, 1'b0);
        wait_issue(base_cnt + 1);
        check("cerr_sticky_after_traffic", credit_err, 1);
        pulse_tov();

        // Reset mid-vector clears everything; only fresh data issues afterwards
        for (int i = 0; i < 20; i++) send_beat(4'h6);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_input_valid", input_valid, 0);
        check("midrst_act_vec", act_vec, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_credit_err", credit_err, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        base_cnt = issue_cnt;
        idle(5);
        check("midrst_no_issue", issue_cnt, base_cnt);
        send_vec(4'h3, 4'h0, 1'b0);
        wait_issue(base_cnt + 1);
        idle(1);
`ifdef CIM_FEEDER_PERF_EN
        check("perf_vec_cnt", perf_vec_cnt, 1);
`endif
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
